// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 prefetching fetch stage.
package lc3_fetch_pkg;

    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;
    localparam logic [LC3_ADDR_W-1:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [LC3_ADDR_W-1:0] pc;
        logic [LC3_DATA_W-1:0] instr;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// In-order prefetch queue of fetch entries; flush wins over push and
// is applied after any pop in the same cycle.
module lc3_fetch_fifo
    import lc3_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [LC3_ADDR_W-1:0] RESET_PC = LC3_RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  fetch_entry_t          push_data,
    input  logic                  pop,
    input  logic                  flush,
    output fetch_entry_t          head,
    output logic [ptr_w(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: RESET_PC, instr: '0};
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

endmodule

// File: rtl/lc3_fetch_prefetch.sv
// LC3 prefetching fetch stage: credit-limited imem reads into a queue.
// Optional perf counters are enabled by defining LC3_FETCH_PERF_EN.
module lc3_fetch_prefetch
    import lc3_fetch_pkg::*;
#(
    parameter int ADDR_W = LC3_ADDR_W,
    parameter int DATA_W = LC3_DATA_W,
    parameter int QDEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = LC3_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] dec_npc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_taddr
`ifdef LC3_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int PW = ptr_w(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

    fetch_state_e      state;
    fetch_state_e      state_nx;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     out_nx;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;
    logic              accept;
    logic              rsp_ok;
    logic              redirect;
    logic              push;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // Queued plus in-flight words never exceed the queue depth.
    assign imem_req_valid = (state == RUN) &&
                            (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
    assign imem_req_addr  = fetch_pc;

    assign accept     = imem_req_valid && imem_req_ready;
    assign rsp_ok     = imem_rsp_valid && (outstanding != '0);
    assign redirect   = br_taken && (state != IDLE);
    assign push       = rsp_ok && (state == RUN) && !redirect;
    assign pop        = dec_valid && dec_ready;
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
    assign out_nx     = outstanding + CW'(accept) - CW'(rsp_ok);

    assign dec_valid = !q_empty;
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;
    assign dec_npc   = head.pc + ADDR_W'(1);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = RUN;
            RUN: begin
                if (redirect && (out_nx != '0)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (out_nx == '0) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_nx;
            outstanding <= out_nx;
            if (redirect) begin
                fetch_pc <= br_taddr;
                rsp_pc   <= br_taddr;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(1);
                end
            end
        end
    end

    lc3_fetch_fifo #(
        .DEPTH    (QDEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && q_full && !pop));

`ifdef LC3_FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Directed bench for lc3_fetch_prefetch with an in-order imem model.
module tb_lc3_fetch_prefetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [15:0] dec_npc;
    logic        br_taken;
    logic [15:0] br_taddr;
`ifdef LC3_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          nacc = 0;
    logic        hold = 1'b0;
    logic [15:0] exp_pc = 16'h3000;
    logic [15:0] first_acc = 16'h0;
    logic [15:0] last_acc = 16'h0;
    logic [15:0] pend [$];

    typedef struct {
        logic        dr;
        logic        rv;
        logic [15:0] ra;
        logic        dv;
        logic [15:0] dp;
    } vec_t;

    vec_t tbl [9];

    lc3_fetch_prefetch dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_npc        (dec_npc),
        .br_taken       (br_taken),
        .br_taddr       (br_taddr)
`ifdef LC3_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: score the handshake, log the request, then play imem.
    task automatic tick();
        logic [15:0] npc;
        if (dec_valid && dec_ready) begin
            npc = exp_pc + 16'd1;
            chk("hs_pc", dec_pc, exp_pc);
            chk("hs_instr", dec_instr, instr_of(exp_pc));
            chk("hs_npc", dec_npc, npc);
            exp_pc = npc;
            hs_cnt++;
        end
        if (imem_req_valid && imem_req_ready) begin
            if (nacc == 0) first_acc = imem_req_addr;
            last_acc = imem_req_addr;
            nacc++;
            pend.push_back(imem_req_addr);
        end
        @(posedge clock);
        #1;
        imem_rsp_valid = 1'b0;
        if (!hold && pend.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend.pop_front());
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        br_taken       = 1'b0;
        br_taddr       = 16'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0;
        hold           = 1'b0;
        pend.delete();
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        exp_pc = 16'h3000;
        hs_cnt = 0;
        nacc   = 0;
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int i = 0; i < 40 && hs_cnt < target; i++) tick();
        chk(name, 32'(hs_cnt), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        logic [15:0] f0;
        tbl[0] = '{1'b1, 1'b0, 16'h3000, 1'b0, 16'h3000};
        tbl[1] = '{1'b1, 1'b1, 16'h3000, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'h3001, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 16'h3002, 1'b1, 16'h3000};
        tbl[4] = '{1'b1, 1'b1, 16'h3003, 1'b1, 16'h3001};
        tbl[5] = '{1'b1, 1'b1, 16'h3004, 1'b1, 16'h3002};
        tbl[6] = '{1'b0, 1'b1, 16'h3005, 1'b1, 16'h3003};
        tbl[7] = '{1'b1, 1'b1, 16'h3006, 1'b1, 16'h3003};
        tbl[8] = '{1'b1, 1'b1, 16'h3007, 1'b1, 16'h3004};

        // Reset values and cycle-by-cycle sequential fetch
        do_reset();
        chk("rst_instr", dec_instr, 16'h0000);
        chk("rst_npc", dec_npc, 16'h3001);
`ifdef LC3_FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
        for (int r = 0; r < 9; r++) begin
            dec_ready = tbl[r].dr;
            chk($sformatf("row%0d_req_valid", r), imem_req_valid, tbl[r].rv);
            chk($sformatf("row%0d_req_addr", r), imem_req_addr, tbl[r].ra);
            chk($sformatf("row%0d_dec_valid", r), dec_valid, tbl[r].dv);
            if (tbl[r].dv || r == 0)
                chk($sformatf("row%0d_dec_pc", r), dec_pc, tbl[r].dp);
            tick();
        end

        // Decode stalled: credit limit caps requests at the queue depth
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        chk("stall_nreq", 32'(nacc), 32'd4);
        chk("stall_first", first_acc, 16'h3000);
        chk("stall_last", last_acc, 16'h3003);
        chk("stall_req_valid", imem_req_valid, 1'b0);
        dec_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("stall_resume", 32'(hs_cnt >= 10), 32'd1);

        // imem back-pressure holds the request address
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_addr0", imem_req_addr, 16'h3004);
        imem_req_ready = 1'b0;
        h0 = nacc;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_held", imem_req_valid, 1'b1);
            chk("bp_addr_held", imem_req_addr, 16'h3004);
            tick();
        end
        chk("bp_no_accept", 32'(nacc), 32'(h0));
        imem_req_ready = 1'b1;
        tick();
        chk("bp_one_accept", 32'(nacc), 32'(h0 + 1));
        chk("bp_accept_addr", last_acc, 16'h3004);
        chk("bp_next_addr", imem_req_addr, 16'h3005);
        for (int i = 0; i < 8; i++) tick();

        // Redirect with two responses still in flight
        do_reset();
        dec_ready = 1'b1;
        hold = 1'b1;
        tick();
        tick();
        tick();
        imem_req_ready = 1'b0;
        chk("rd_outstanding", 32'(nacc), 32'd2);
        br_taken = 1'b1;
        br_taddr = 16'h4000;
        tick();
        br_taken = 1'b0;
        exp_pc = 16'h4000;
        hold = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rd_drain_req", imem_req_valid, 1'b0);
            chk("rd_drain_dv", dec_valid, 1'b0);
            tick();
        end
        chk("rd_run_req", imem_req_valid, 1'b1);
        chk("rd_run_addr", imem_req_addr, 16'h4000);
        wait_hs(1, "rd_first_hs");

        // Address wrap FFFF -> 0000
        do_reset();
        dec_ready = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        br_taken = 1'b1;
        br_taddr = 16'hFFFE;
        tick();
        br_taken = 1'b0;
        exp_pc = 16'hFFFE;
        imem_req_ready = 1'b1;
        wait_hs(4, "wrap_hs");
        chk("wrap_first_req", first_acc, 16'hFFFE);
        chk("wrap_exp_pc", exp_pc, 16'h0002);

        // Redirect coinciding with a handshake and a response
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("co_dv", dec_valid, 1'b1);
        chk("co_rsp", imem_rsp_valid, 1'b1);
`ifdef LC3_FETCH_PERF_EN
        f0 = perf_flush_cnt;
`else
        f0 = 16'h0;
`endif
        h0 = hs_cnt;
        br_taken = 1'b1;
        br_taddr = 16'h5000;
        tick();
        br_taken = 1'b0;
        exp_pc = 16'h5000;
        chk("co_hs_counted", 32'(hs_cnt), 32'(h0 + 1));
        chk("co_flushed", dec_valid, 1'b0);
        chk("co_drain", imem_req_valid, 1'b0);
`ifdef LC3_FETCH_PERF_EN
        chk("co_perf_flush", 32'(perf_flush_cnt), 32'(f0 + 16'd1));
        chk("co_perf_fetch", perf_fetch_cnt, 32'(hs_cnt));
`else
        chk("co_flush_base", 32'(f0), 32'd0);
`endif
        wait_hs(h0 + 2, "co_next_hs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_prefetch.md
Name: lc3_fetch_prefetch

Overview:
- Prefetching instruction-fetch stage of the LC3 pipeline. It issues sequential instruction reads to the imem port and buffers the returned words in a small in-order queue.
- It presents {instr, pc, npc} to the decode stage over a valid/ready handshake.
- A taken branch or jump from execute/control redirects the fetch PC, flushes the queue and discards in-flight responses.
- Sits between imem and decode; its output feeds the decode stage directly.

Parameters:
- ADDR_W, 16, instruction address width.
- DATA_W, 16, instruction word width.
- QDEPTH, 4, prefetch queue depth; also the maximum of queued plus outstanding requests; power of two, >= 2.
- RESET_PC, 16'h3000, fetch PC after reset.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  imem accepts the request this cycle.
- imem_req_addr  out  ADDR_W  read address.
- imem_rsp_valid  in  1  read data valid; responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_W  read data.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  DATA_W  head instruction.
- dec_pc  out  ADDR_W  address of the head instruction.
- dec_npc  out  ADDR_W  dec_pc+1, modulo 2^ADDR_W.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_taddr  in  ADDR_W  redirect target.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; fetch_pc = rsp_pc = RESET_PC.
  - Queue empty; outstanding = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - dec_valid = 0, dec_instr = 0, dec_pc = RESET_PC, dec_npc = RESET_PC+1.
- States:
  - IDLE: one cycle after reset deassertion, then RUN.
  - RUN: normal fetching.
  - DRAIN: discarding stale responses after a redirect.
- Request rule in RUN: imem_req_valid = (outstanding + count < QDEPTH); imem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 1, wrapping FFFF->0000, and outstanding += 1.
  - While valid && !ready, the address is held stable. Only a redirect may withdraw an unaccepted request.
- Response rule:
  - Every response decrements outstanding.
  - In RUN, a response pushes {imem_rsp_data, rsp_pc} and rsp_pc += 1 (wrapping).
  - The credit rule guarantees the queue cannot overflow. Overflow is an assertion failure.
- Decode handshake: the head is popped when dec_valid && dec_ready. Output fields are registered from the queue head (no combinational rsp->dec path). A full queue can be popped and pushed in the same cycle.
- Redirect (br_taken = 1), any state except IDLE:
  - Queue cleared; fetch_pc = rsp_pc = br_taddr; dec_valid = 0 next cycle.
  - A pop in the same cycle still completes before the clear.
  - A request accepted in the same cycle counts as outstanding and its response is dropped.
  - A response arriving in the same cycle is dropped.
  - Next state: DRAIN if the post-update outstanding > 0, else RUN.
- DRAIN:
  - imem_req_valid = 0.
  - Responses are decremented and discarded.
  - When outstanding reaches 0, go to RUN. The first request is issued in the RUN cycle.
  - A further br_taken in DRAIN retargets fetch_pc/rsp_pc and the block stays in DRAIN.
- br_taken during IDLE is ignored.
- Reset mid-operation: all state returns to reset values immediately; in-flight imem responses after reset are the environment's responsibility (imem is reset too).

Optional Feature:
- LC3_FETCH_PERF_EN: adds output perf_fetch_cnt[31:0] and output perf_flush_cnt[15:0].
  - perf_fetch_cnt counts decode handshakes.
  - perf_flush_cnt counts accepted redirects.
  - Both counters saturate and reset to 0.
- Without the macro: the ports and counters are absent. Other behaviour is identical.

Decomposition:
- Package lc3_fetch_pkg:
  - fetch_state_e {IDLE, RUN, DRAIN}.
  - fetch_entry_t {pc, instr}.
  - LC3_RESET_PC constant.
  - Queue pointer width function (log2 QDEPTH).
- Sub-module lc3_fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, synchronous flush, count, full, empty.
  - Flush has priority over push and is applied after pop.

Test Plan:
- Reset then imem always ready, 1-cycle latency, dec_ready = 1 -> dec_pc sequence 3000, 3001, 3002…; dec_npc = dec_pc+1; first dec_valid no later than cycle 4 after reset release.
- dec_ready = 0 for 20 cycles -> exactly 4 requests issued (addresses 3000-3003), then imem_req_valid = 0; releasing dec_ready resumes at 3004 with no lost or duplicated words.
- imem_req_ready low for 3 cycles with a request pending -> imem_req_addr held at the same value; accepted once when ready rises.
- Two requests outstanding, br_taken with taddr = 4000 -> both stale responses discarded, no requests issued until outstanding = 0, next dec_pc = 4000 with its correct instruction.
- fetch_pc = FFFF -> dec_pc FFFF with dec_npc 0000, followed by dec_pc 0000.
- br_taken in the same cycle as a dec handshake and an imem response -> handshake counted, response dropped, queue empty next cycle; with LC3_FETCH_PERF_EN, perf_flush_cnt increments by 1.
